// File: rtl/multi_edge_detector_if.sv
// Bundle of per-channel input controls and status outputs of the edge detector.
// The master side drives raw inputs and controls; the slave side is the detector.
interface multi_edge_detector_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    logic [N_CH-1:0]       signal;
    logic [2*N_CH-1:0]     mode;
    logic [N_CH-1:0]       sticky_clr;
    logic [N_CH-1:0]       count_clr;
    logic [N_CH-1:0]       level;
    logic [N_CH-1:0]       pulse;
    logic [N_CH-1:0]       sticky;
    logic [N_CH*CNT_W-1:0] count;
    logic                  irq;

    modport master (
        output signal, mode, sticky_clr, count_clr,
        input  level, pulse, sticky, count, irq
    );

    modport slave (
        input  signal, mode, sticky_clr, count_clr,
        output level, pulse, sticky, count, irq
    );
endinterface

// File: rtl/multi_edge_detector.sv
// N-channel edge detector: synchroniser, debounce filter, per-channel edge mode,
// one-cycle event pulse, sticky flag with clear, saturating event counter.
// irq is the OR of the sticky flags.
module multi_edge_detector #(
    parameter int   N_CH        = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   DEBOUNCE    = 4,
    parameter int   CNT_W       = 8,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    multi_edge_detector_if.slave  bus
);
    // Debounce counter only has to reach DEBOUNCE-1; the extra bit keeps
    // DEBOUNCE=1 legal with a one-bit counter.
    localparam int              DB_W    = $clog2(DEBOUNCE) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;

    logic [N_CH-1:0]       level_vec;
    logic [N_CH-1:0]       pulse_vec;
    logic [N_CH-1:0]       sticky_vec;
    logic [N_CH*CNT_W-1:0] count_vec;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   s_last;
            logic [DB_W-1:0]        db_cnt_reg;
            logic [DB_W-1:0]        db_cnt_next;
            logic                   level_reg;
            logic                   level_next;
            logic                   raw_edge;
            logic [1:0]             ch_mode;
            logic                   event_next;
            logic                   pulse_reg;
            logic                   sticky_reg;
            logic                   sticky_next;
            logic [CNT_W-1:0]       cnt_reg;
            logic [CNT_W-1:0]       cnt_next;

            assign s_last  = sync_reg[SYNC_STAGES-1];
            assign ch_mode = bus.mode[2*gi +: 2];

            // Synchroniser chain: stage 0 samples the raw pin, later stages shift up.
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_reg <= {SYNC_STAGES{RESET_LEVEL}};
                end else begin
                    sync_reg <= SYNC_STAGES'({sync_reg, bus.signal[gi]});
                end
            end

            // Debounce: the level flips only after DEBOUNCE consecutive mismatches.
            always_comb begin
                db_cnt_next = db_cnt_reg;
                level_next  = level_reg;
                raw_edge    = 1'b0;
                if (s_last == level_reg) begin
                    db_cnt_next = '0;
                end else if (db_cnt_reg == DB_LAST) begin
                    db_cnt_next = '0;
                    level_next  = s_last;
                    raw_edge    = 1'b1;
                end else begin
                    db_cnt_next = db_cnt_reg + 1'b1;
                end
            end

            // Edge qualification by mode; the new level decides rise versus fall.
            always_comb begin
                event_next = 1'b0;
                case (ch_mode)
                    MODE_RISE: event_next = raw_edge &  level_next;
                    MODE_FALL: event_next = raw_edge & ~level_next;
                    MODE_BOTH: event_next = raw_edge;
                    default:   event_next = 1'b0;
                endcase
            end

            // Sticky flag and saturating counter; a coincident event wins over a clear.
            always_comb begin
                sticky_next = sticky_reg;
                cnt_next    = cnt_reg;
                if (event_next) begin
                    sticky_next = 1'b1;
                end else if (bus.sticky_clr[gi]) begin
                    sticky_next = 1'b0;
                end
                if (bus.count_clr[gi]) begin
                    cnt_next = event_next ? CNT_W'(1) : '0;
                end else if (event_next && (cnt_reg != CNT_MAX)) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            // Per-channel state registers; level and pulse update on the same edge.
            always_ff @(posedge clk) begin
                if (reset) begin
                    db_cnt_reg <= '0;
                    level_reg  <= RESET_LEVEL;
                    pulse_reg  <= 1'b0;
                    sticky_reg <= 1'b0;
                    cnt_reg    <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_next;
                    level_reg  <= level_next;
                    pulse_reg  <= event_next;
                    sticky_reg <= sticky_next;
                    cnt_reg    <= cnt_next;
                end
            end

            assign level_vec[gi]                = level_reg;
            assign pulse_vec[gi]                = pulse_reg;
            assign sticky_vec[gi]               = sticky_reg;
            assign count_vec[CNT_W*gi +: CNT_W] = cnt_reg;
        end
    endgenerate

    assign bus.level  = level_vec;
    assign bus.pulse  = pulse_vec;
    assign bus.sticky = sticky_vec;
    assign bus.count  = count_vec;
    // irq comes only from sticky flops, so it cannot glitch on input activity.
    assign bus.irq    = |sticky_vec;
endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector (N_CH=4, SYNC_STAGES=2, DEBOUNCE=4, CNT_W=4).
module tb_multi_edge_detector;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    multi_edge_detector_if #(.N_CH(4), .CNT_W(4)) bus_if ();

    multi_edge_detector #(
        .N_CH(4), .SYNC_STAGES(2), .DEBOUNCE(4), .CNT_W(4), .RESET_LEVEL(1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-20s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        int exp_cnt[4];
        exp_cnt = '{1, 2, 3, 0};

        // Reset with all inputs at the reset level
        reset              = 1'b1;
        bus_if.signal      = 4'b1111;
        bus_if.mode        = 8'b00_00_10_00;   // ch1 both, others rise
        bus_if.sticky_clr  = 4'b0000;
        bus_if.count_clr   = 4'b0000;
        step(3);
        check("rst_level",  32'(bus_if.level),  32'hF);
        check("rst_pulse",  32'(bus_if.pulse),  32'h0);
        check("rst_sticky", 32'(bus_if.sticky), 32'h0);
        check("rst_count",  32'(bus_if.count),  32'h0);
        check("rst_irq",    32'(bus_if.irq),    32'h0);
        reset = 1'b0;

        // ch0 falls in rise mode: level follows, no event
        bus_if.signal[0] = 1'b0;
        step(20);
        check("ch0_fall_level",  32'(bus_if.level[0]), 32'h0);
        check("ch0_fall_sticky", 32'(bus_if.sticky),   32'h0);
        check("ch0_fall_irq",    32'(bus_if.irq),      32'h0);

        // ch0 rises: pulse exactly after edge k+5
        bus_if.signal[0] = 1'b1;
        step(5);
        check("lat_pulse_early", 32'(bus_if.pulse[0]), 32'h0);
        check("lat_level_early", 32'(bus_if.level[0]), 32'h0);
        step(1);
        check("lat_pulse",  32'(bus_if.pulse[0]),    32'h1);
        check("lat_level",  32'(bus_if.level[0]),    32'h1);
        check("lat_sticky", 32'(bus_if.sticky[0]),   32'h1);
        check("lat_count",  32'(bus_if.count[3:0]),  32'h1);
        check("lat_irq",    32'(bus_if.irq),         32'h1);
        step(1);
        check("lat_pulse_end", 32'(bus_if.pulse[0]), 32'h0);

        // Sticky clear, then clear coincident with a new event
        bus_if.sticky_clr[0] = 1'b1;
        step(1);
        bus_if.sticky_clr[0] = 1'b0;
        check("clr_sticky", 32'(bus_if.sticky[0]), 32'h0);
        check("clr_irq",    32'(bus_if.irq),       32'h0);
        bus_if.signal[0] = 1'b0;
        step(10);
        bus_if.signal[0] = 1'b1;
        step(5);
        bus_if.sticky_clr[0] = 1'b1;
        step(1);
        check("race_pulse",  32'(bus_if.pulse[0]),   32'h1);
        check("race_sticky", 32'(bus_if.sticky[0]),  32'h1);
        check("race_count",  32'(bus_if.count[3:0]), 32'h2);
        step(1);
        bus_if.sticky_clr[0] = 1'b0;
        check("race_clr_sticky", 32'(bus_if.sticky[0]), 32'h0);
        check("race_clr_irq",    32'(bus_if.irq),       32'h0);

        // ch1 glitch of 3 cycles is filtered out
        bus_if.signal[1] = 1'b0;
        step(3);
        bus_if.signal[1] = 1'b1;
        step(15);
        check("glitch_level",  32'(bus_if.level[1]),  32'h1);
        check("glitch_count",  32'(bus_if.count[7:4]), 32'h0);
        check("glitch_sticky", 32'(bus_if.sticky[1]), 32'h0);

        // ch1 low for 4 cycles passes: fall then rise, both reported in mode both
        bus_if.signal[1] = 1'b0;
        step(4);
        bus_if.signal[1] = 1'b1;
        step(2);
        check("db4_fall_pulse", 32'(bus_if.pulse[1]), 32'h1);
        check("db4_fall_level", 32'(bus_if.level[1]), 32'h0);
        step(4);
        check("db4_rise_pulse", 32'(bus_if.pulse[1]), 32'h1);
        check("db4_rise_level", 32'(bus_if.level[1]), 32'h1);
        step(5);
        check("db4_count",  32'(bus_if.count[7:4]), 32'h2);
        check("db4_sticky", 32'(bus_if.sticky[1]),  32'h1);

        // ch2 modes: post-reset fall, then high, then low
        for (int m = 0; m < 4; m++) begin
            reset = 1'b1;
            bus_if.signal[2]   = 1'b0;
            bus_if.mode[5:4]   = 2'(m);
            step(2);
            check("mode_rst_count", 32'(bus_if.count), 32'h0);
            reset = 1'b0;
            step(10);
            check("mode_level_lo1", 32'(bus_if.level[2]), 32'h0);
            bus_if.signal[2] = 1'b1;
            step(10);
            check("mode_level_hi", 32'(bus_if.level[2]), 32'h1);
            bus_if.signal[2] = 1'b0;
            step(10);
            check("mode_level_lo2", 32'(bus_if.level[2]), 32'h0);
            check("mode_count", 32'(bus_if.count[11:8]), 32'(exp_cnt[m]));
        end

        // ch3 saturation at 15 after 20 rising edges
        for (int i = 0; i < 20; i++) begin
            bus_if.signal[3] = 1'b0;
            step(6);
            bus_if.signal[3] = 1'b1;
            step(6);
        end
        step(6);
        check("sat_count", 32'(bus_if.count[15:12]), 32'hF);

        // count_clr together with an event gives 1, alone gives 0
        bus_if.signal[3] = 1'b0;
        step(8);
        bus_if.signal[3] = 1'b1;
        step(5);
        bus_if.count_clr[3] = 1'b1;
        step(1);
        check("cclr_evt_pulse", 32'(bus_if.pulse[3]),     32'h1);
        check("cclr_evt_count", 32'(bus_if.count[15:12]), 32'h1);
        step(1);
        bus_if.count_clr[3] = 1'b0;
        check("cclr_count", 32'(bus_if.count[15:12]), 32'h0);

        // Reset two cycles into a ch0 rising debounce
        bus_if.signal[0] = 1'b0;
        step(10);
        check("mid_pre_level", 32'(bus_if.level[0]), 32'h0);
        bus_if.signal[0] = 1'b1;
        step(4);
        reset = 1'b1;
        step(1);
        check("mid_rst_level",  32'(bus_if.level),  32'hF);
        check("mid_rst_pulse",  32'(bus_if.pulse),  32'h0);
        check("mid_rst_sticky", 32'(bus_if.sticky), 32'h0);
        check("mid_rst_count",  32'(bus_if.count),  32'h0);
        check("mid_rst_irq",    32'(bus_if.irq),    32'h0);
        reset = 1'b0;
        step(10);
        check("mid_post_pulse",  32'(bus_if.pulse),  32'h0);
        check("mid_post_sticky", 32'(bus_if.sticky), 32'h0);
        check("mid_post_count",  32'(bus_if.count),  32'h0);
        check("mid_post_level",  32'(bus_if.level),  32'hB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
